// File: rtl/arb_pkg.sv
// Shared types and one-hot helpers for the round-robin accelerator arbiter.
package arb_pkg;

  // Widest requester vector the helper functions handle.
  localparam int MAX_REQ = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary index of the set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_bin(input logic [MAX_REQ-1:0] oh);
    int unsigned b;
    b = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) b = b | unsigned'(i);
    end
    return b;
  endfunction

  // Rotate a one-hot vector of n live bits left by one, bit n-1 wrapping to bit 0.
  function automatic logic [MAX_REQ-1:0] rotl1(input logic [MAX_REQ-1:0] oh, input int n);
    logic [MAX_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n && oh[i]) r[(i+1)%n] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above the one-hot
// pointer, wrapping circularly, found by a double-width masked priority encode.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] winner
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] thr;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Mask off bits below ptr in the doubled request, then isolate the lowest set
  // bit; folding both halves back together gives the circular wrap.
  always_comb begin
    dreq   = {req, req};
    thr    = {{N{1'b0}}, ptr};
    masked = dreq & ~(thr - 1'b1);
    first  = masked & (~masked + 1'b1);
    winner = first[N-1:0] | first[2*N-1:N];
  end

endmodule

// File: rtl/rr_accel_arbiter.sv
// Round-robin arbiter sharing one accelerator among NUM_REQ requesters.
// Grant is registered, held until done / withdrawal / hold timeout, then
// released for one dead cycle with the pointer moved past the last winner.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant; pick the next winner from req starting at ptr
//   GRANT | grant held; count hold cycles and watch done/withdraw/timeout
module rr_accel_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout
);

  localparam int CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] winner;
  logic               win_held;
  logic               tmo_hit;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner)
  );

  assign win_held = |(req & grant_q);
  // The hold limit is only meaningful with a non-zero MAX_HOLD.
  assign tmo_hit  = (MAX_HOLD > 0) && (cnt_q == CNT_W'(HOLD_LAST));

  // State, pointer, hold counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= NUM_REQ'(1);
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: grant from IDLE, release from GRANT on the first release cause.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = winner;
          state_d = GRANT;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (done || !win_held || tmo_hit) begin
          grant_d   = '0;
          state_d   = IDLE;
          ptr_d     = NUM_REQ'(rotl1(MAX_REQ'(grant_q), NUM_REQ));
          // A coincident done or withdrawal makes this an ordinary release.
          timeout_d = tmo_hit && !done && win_held;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output views of the registered grant.
  always_comb begin
    grant       = grant_q;
    grant_valid = |grant_q;
    grant_id    = ID_W'(onehot_to_bin(MAX_REQ'(grant_q)));
    timeout     = timeout_q;
  end

endmodule
